// File: rtl/instr_fetch.sv
// Instruction fetch unit: FETCH/ISSUE handshake with imem, PC register and next-PC selection.
// Optional fetch timeout with sticky error flag is enabled by defining INSTR_FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        zero,
    input  logic        mux_branch_jump,
    input  logic        stall,
    output logic        fetch_err
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_imem_req;
    logic        r_instr_valid;
    logic        r_fetch_err;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;
    logic [31:0] w_next_pc;

`ifdef INSTR_FETCH_TIMEOUT_EN
    logic [7:0]  r_to_cnt;
`endif

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_branch_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    // Next-PC select: jump has priority over a taken branch; all sums wrap modulo 2^32.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (!mux_branch_jump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (branch && zero) begin
            w_next_pc = w_pc_plus4 + w_branch_off;
        end else begin
            w_next_pc = w_pc_plus4;
        end
    end

    // Fetch/issue state machine with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0000_0000;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
`ifdef INSTR_FETCH_TIMEOUT_EN
            r_to_cnt      <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (r_imem_req && imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_state       <= S_ISSUE;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
`ifdef INSTR_FETCH_TIMEOUT_EN
                        r_to_cnt      <= 8'd0;
`endif
                    end else begin
`ifdef INSTR_FETCH_TIMEOUT_EN
                        // A timeout drops the request for one cycle, then retries the same pc.
                        if (!r_imem_req) begin
                            r_imem_req <= 1'b1;
                        end else if (r_to_cnt == 8'd254) begin
                            r_fetch_err <= 1'b1;
                            r_imem_req  <= 1'b0;
                            r_to_cnt    <= 8'd0;
                        end else begin
                            r_to_cnt    <= r_to_cnt + 8'd1;
                        end
`else
                        r_imem_req <= 1'b1;
`endif
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        r_pc          <= w_next_pc;
                        r_state       <= S_FETCH;
                        r_imem_req    <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end else begin
                        r_state       <= S_ISSUE;
                    end
                end
                default: begin
                    r_state       <= S_FETCH;
                    r_imem_req    <= 1'b1;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against an arithmetic next-PC model.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        mux_branch_jump = 1'b1;
    logic        stall = 1'b0;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_pc;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .branch(branch),
        .zero(zero), .mux_branch_jump(mux_branch_jump), .stall(stall), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; stall = 1'b0;
        step(); step();
        rst = 1'b0;
        m_pc = RST_PC;
        checks++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 || pc !== RST_PC || instr !== 32'h0 || fetch_err !== 1'b0)
            begin errors++; $display("FAIL reset req=%b valid=%b pc=%h instr=%h err=%b expected 1 0 %h 0 0", imem_req, instr_valid, pc, instr, fetch_err, RST_PC); end
    endtask

    // One instruction: wait dly cycles, ack, hold for nstall cycles, then resolve next pc.
    task automatic fetch_issue(input logic [31:0] data, input logic br, input logic z,
                               input logic mbj, input int dly, input int nstall);
        logic [31:0] p4;
        logic [31:0] exp_pc;
        logic signed [15:0] imm;
        int off;
        for (int k = 0; k <= dly; k++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0)
                begin errors++; $display("FAIL fetch_wait req=%b addr=%h valid=%b expected 1 %h 0", imem_req, imem_addr, instr_valid, m_pc); end
            if (k < dly) begin
                imem_ack = 1'b0; imem_rdata = $urandom; step();
            end
        end
        imem_ack = 1'b1; imem_rdata = data; step();
        imem_ack = 1'b0;
        for (int k = 0; k <= nstall; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== data || opcode !== data[31:26] || pc !== m_pc || pc_plus4 !== m_pc + 32'd4)
                begin errors++; $display("FAIL issue valid=%b req=%b instr=%h op=%b pc=%h p4=%h expected 1 0 %h %b %h %h", instr_valid, imem_req, instr, opcode, pc, pc_plus4, data, data[31:26], m_pc, m_pc + 32'd4); end
            if (k < nstall) begin
                stall = 1'b1; branch = 1'($urandom); zero = 1'($urandom); mux_branch_jump = 1'($urandom);
                imem_ack = 1'($urandom); imem_rdata = $urandom;
                step();
                imem_ack = 1'b0;
            end
        end
        stall = 1'b0; branch = br; zero = z; mux_branch_jump = mbj;
        step();
        branch = 1'($urandom); zero = 1'($urandom); mux_branch_jump = 1'($urandom);
        p4 = m_pc + 32'd4;
        imm = data[15:0];
        off = imm;
        if (!mbj) exp_pc = (p4 & 32'hF000_0000) + ((data & 32'h03FF_FFFF) * 32'd4);
        else if (br && z) exp_pc = p4 + 32'(off * 4);
        else exp_pc = p4;
        m_pc = exp_pc;
        checks++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 || pc !== m_pc || imem_addr !== m_pc || fetch_err !== 1'b0)
            begin errors++; $display("FAIL next_pc req=%b valid=%b pc=%h addr=%h err=%b expected 1 0 %h %h 0", imem_req, instr_valid, pc, imem_addr, fetch_err, m_pc, m_pc); end
    endtask

    task automatic test_directed();
        fetch_issue(32'h8C08_0004, 1'b0, 1'b0, 1'b1, 2, 0);   // lw, pc 0 -> 4
        fetch_issue(32'h0800_0010, 1'b0, 1'b0, 1'b0, 0, 0);   // jump to 0x40
        fetch_issue(32'h1100_FFFF, 1'b1, 1'b1, 1'b1, 1, 0);   // taken branch back to 0x40
        fetch_issue(32'h1100_FFFF, 1'b1, 1'b0, 1'b1, 0, 1);   // not taken -> 0x44
        fetch_issue(32'h1000_FFED, 1'b1, 1'b1, 1'b1, 0, 0);   // branch wraps to 0xFFFFFFFC
        fetch_issue(32'h0000_0020, 1'b0, 1'b0, 1'b1, 0, 3);   // pc+4 wraps to 0, stalled 3
        fetch_issue(32'h0BFF_FFFF, 1'b0, 1'b0, 1'b0, 0, 0);   // jump to 0x0FFFFFFC
        fetch_issue(32'h0000_0020, 1'b0, 1'b0, 1'b1, 0, 0);   // -> 0x10000000
        fetch_issue(32'h0800_0010, 1'b1, 1'b1, 1'b0, 0, 0);   // jump wins -> 0x10000040
        checks++;
        if (m_pc !== 32'h1000_0040 || pc !== 32'h1000_0040)
            begin errors++; $display("FAIL jump_priority pc=%h expected 10000040", pc); end
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; step();
        rst = 1'b0; imem_ack = 1'b0; m_pc = RST_PC;
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b0 || pc !== RST_PC || imem_req !== 1'b1)
            begin errors++; $display("FAIL reset_ack instr=%h valid=%b pc=%h req=%b expected 0 0 %h 1", instr, instr_valid, pc, imem_req, RST_PC); end
        imem_ack = 1'b1; imem_rdata = 32'h0BFF_FFFF; step();
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h0BFF_FFFF)
            begin errors++; $display("FAIL pre_issue valid=%b instr=%h expected 1 0bffffff", instr_valid, instr); end
        rst = 1'b1; stall = 1'b0; mux_branch_jump = 1'b0; imem_ack = 1'b1; step();
        rst = 1'b0; imem_ack = 1'b0; mux_branch_jump = 1'b1;
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b0 || pc !== RST_PC || imem_req !== 1'b1)
            begin errors++; $display("FAIL reset_issue instr=%h valid=%b pc=%h req=%b expected 0 0 %h 1", instr, instr_valid, pc, imem_req, RST_PC); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic mbj;
        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            mbj = ($urandom_range(0, 3) != 0);
            fetch_issue(d, 1'($urandom), 1'($urandom), mbj, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_timeout();
        int n;
        rst = 1'b1; imem_ack = 1'b0; step();
        rst = 1'b0; m_pc = RST_PC;
`ifdef INSTR_FETCH_TIMEOUT_EN
        n = 0;
        while (imem_req === 1'b1 && n < 400) begin
            n++; step();
        end
        checks++;
        if (n !== 255 || fetch_err !== 1'b1 || imem_addr !== m_pc)
            begin errors++; $display("FAIL timeout cycles=%0d err=%b addr=%h expected 255 1 %h", n, fetch_err, imem_addr, m_pc); end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc || fetch_err !== 1'b1)
            begin errors++; $display("FAIL retry req=%b addr=%h err=%b expected 1 %h 1", imem_req, imem_addr, fetch_err, m_pc); end
`else
        for (n = 0; n < 300; n++) begin
            checks++;
            if (imem_req !== 1'b1 || fetch_err !== 1'b0 || imem_addr !== m_pc)
                begin errors++; $display("FAIL no_timeout cycle=%0d req=%b err=%b addr=%h expected 1 0 %h", n, imem_req, fetch_err, imem_addr, m_pc); end
            step();
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_priority();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
